// File: rtl/din_syn_receiver.sv
// Receive side of the DIN/SYN link: oversamples the serial triple, deserializes one
// frame, reports length/timeout errors and compares the frame against an expected pattern.
module din_syn_receiver #(
    parameter int TOTAL_BITS = 490,
    parameter int CNT_W      = 10,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  ser_clk,
    input  logic                  ser_din,
    input  logic                  ser_syn,
    input  logic [TOTAL_BITS-1:0] expect_reg,
    output logic [TOTAL_BITS-1:0] data_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  match,
    output logic                  busy
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int IDX_W = $clog2(TOTAL_BITS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [2:0] clk_sync_q, din_sync_q, syn_sync_q;
    logic       evt, din_s, syn_s;

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [TOTAL_BITS-1:0] capture_q, capture_d;
    logic [TOTAL_BITS-1:0] data_out_q, data_out_d;
    logic                  match_q, match_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [CNT_W-1:0]      bit_count_q, bit_count_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q, frame_err_d;

    // Bit [0] is s1, [1] is s2, [2] is s3; the edge is judged between s2 and s3.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_sync_q <= '0;
            din_sync_q <= '0;
            syn_sync_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ser_clk};
            din_sync_q <= {din_sync_q[1:0], ser_din};
            syn_sync_q <= {syn_sync_q[1:0], ser_syn};
        end
    end

    assign evt   = clk_sync_q[1] & ~clk_sync_q[2];
    assign din_s = din_sync_q[1];
    assign syn_s = syn_sync_q[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        timer_d       = timer_q;
        capture_d     = capture_q;
        data_out_d    = data_out_q;
        match_d       = match_q;
        err_code_d    = err_code_q;
        bit_count_d   = bit_count_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (evt && !syn_s) begin
                    capture_d[0] = din_s;
                    cnt_d        = CNT_W'(1);
                    ovf_d        = 1'b0;
                    timer_d      = '0;
                    state_d      = S_RECV;
                end else if (evt) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                    bit_count_d = '0;
                end
            end
            S_RECV: begin
                if (evt && !syn_s) begin
                    if (cnt_q < CNT_FULL) begin
                        capture_d[cnt_q[IDX_W-1:0]] = din_s;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    timer_d = '0;
                end else if (evt) begin
                    // Frame end: the din sampled alongside syn carries no data.
                    if (ovf_q) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LONG;
                    end else if (cnt_q == CNT_FULL) begin
                        frame_valid_d = 1'b1;
                        err_code_d    = ERR_NONE;
                        data_out_d    = capture_q;
                        match_d       = (capture_q == expect_reg);
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_SHORT;
                    end
                    bit_count_d = cnt_q;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    timer_d     = '0;
                    state_d     = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TMO;
                    bit_count_d = cnt_q;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    timer_d     = '0;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            timer_q       <= '0;
            data_out_q    <= '0;
            match_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            bit_count_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            timer_q       <= timer_d;
            data_out_q    <= data_out_d;
            match_q       <= match_d;
            err_code_q    <= err_code_d;
            bit_count_q   <= bit_count_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Shift storage only; every bit is rewritten before a frame can be accepted.
    always_ff @(posedge clk_in) begin
        capture_q <= capture_d;
    end

    assign data_out    = data_out_q;
    assign match       = match_q;
    assign err_code    = err_code_q;
    assign bit_count   = bit_count_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == S_RECV);

endmodule

// File: tb/tb_din_syn_receiver.sv
// Directed bench for din_syn_receiver: a frame-level model predicts each frame-end
// pulse and the held outputs, and a per-cycle compare process checks the DUT against it.
module tb_din_syn_receiver;

    localparam int NB  = 490;
    localparam int CW  = 10;
    localparam int TMO = 4096;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          ser_clk = 1'b0;
    logic          ser_din = 1'b0;
    logic          ser_syn = 1'b0;
    logic [NB-1:0] expect_reg = '0;
    logic [NB-1:0] data_out;
    logic          frame_valid, frame_err, match, busy;
    logic [1:0]    err_code;
    logic [CW-1:0] bit_count;

    always #5 clk_in = ~clk_in;

    din_syn_receiver #(.TOTAL_BITS(NB), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk_in(clk_in), .rst(rst), .ser_clk(ser_clk), .ser_din(ser_din), .ser_syn(ser_syn),
        .expect_reg(expect_reg), .data_out(data_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_code(err_code), .bit_count(bit_count),
        .match(match), .busy(busy)
    );

    typedef struct {
        logic          is_valid;
        logic [1:0]    code;
        int            bc;
        logic [NB-1:0] data;
        logic          m;
        int            lo;
        int            hi;
    } ev_t;

    ev_t           evq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_rise = 0;
    int            n_valid = 0;
    logic [NB-1:0] m_data = '0;
    logic          m_match = 1'b0;
    logic [1:0]    m_code = 2'b00;
    int            m_bc = 0;

    task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Per-cycle compare, sampled 1 ns after the active edge.
    always @(posedge clk_in) begin
        ev_t ev;
        #1;
        cyc++;
        if (rst) begin
            m_data  = '0;
            m_match = 1'b0;
            m_code  = 2'b00;
            m_bc    = 0;
        end else begin
            checks++;
            if (frame_valid && frame_err) begin
                errors++;
                $display("FAIL both_pulses at cycle %0d", cyc);
            end
            if (frame_valid) n_valid++;
            if (frame_valid || frame_err) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse at cycle %0d: valid=%0b err=%0b", cyc, frame_valid, frame_err);
                end else begin
                    ev = evq.pop_front();
                    if (frame_valid !== ev.is_valid || err_code !== ev.code ||
                        bit_count !== CW'(ev.bc) || cyc < ev.lo || cyc > ev.hi) begin
                        errors++;
                        $display("FAIL frame_end: got valid=%0b code=%0d count=%0d cycle=%0d, expected valid=%0b code=%0d count=%0d cycle %0d..%0d",
                                 frame_valid, err_code, bit_count, cyc, ev.is_valid, ev.code, ev.bc, ev.lo, ev.hi);
                    end
                    m_code = ev.code;
                    m_bc   = ev.bc;
                    if (ev.is_valid) begin
                        m_data  = ev.data;
                        m_match = ev.m;
                    end
                end
            end
        end
        chk("data_out", data_out, m_data);
        chk("held_status", {match, err_code, bit_count}, {m_match, m_code, CW'(m_bc)});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic ser_period(input logic d, input logic s);
        ser_clk = 1'b0;
        ser_din = d;
        ser_syn = s;
        tick(4);
        ser_clk   = 1'b1;
        last_rise = cyc;
        tick(4);
    endtask

    task automatic idle(input int n);
        ser_clk = 1'b0;
        ser_syn = 1'b0;
        ser_din = 1'b0;
        tick(n);
    endtask

    task automatic send_bits(input logic [NB-1:0] pat, input int n, input logic fill);
        for (int i = 0; i < n; i++) begin
            if (i < NB) ser_period(pat[i], 1'b0);
            else        ser_period(fill, 1'b0);
        end
    endtask

    // Close the frame with a syn period after n data bits.
    task automatic end_syn(input logic [NB-1:0] pat, input int n, input logic [NB-1:0] expv);
        ev_t ev;
        ev.is_valid = (n == NB);
        ev.code     = (n == NB) ? 2'b00 : ((n < NB) ? 2'b01 : 2'b10);
        ev.bc       = (n > 1023) ? 1023 : n;
        ev.data     = pat;
        ev.m        = (pat == expv);
        ser_clk = 1'b0;
        ser_din = 1'b0;
        ser_syn = 1'b1;
        tick(4);
        ev.lo = cyc + 2;
        ev.hi = cyc + 6;
        evq.push_back(ev);
        ser_clk = 1'b1;
        tick(4);
    endtask

    task automatic end_timeout(input int n);
        ev_t ev;
        ev.is_valid = 1'b0;
        ev.code     = 2'b11;
        ev.bc       = n;
        ev.data     = '0;
        ev.m        = 1'b0;
        ev.lo       = last_rise + TMO;
        ev.hi       = last_rise + TMO + 8;
        evq.push_back(ev);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (evq.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (evq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d frame-end pulses missing, expected 0", evq.size());
            evq.delete();
        end
        tick(2);
    endtask

    logic [NB-1:0] pat, pat2, ones;
    logic [7:0]    a5, c3;
    int            nv0;

    initial begin
        a5 = 8'hA5;
        c3 = 8'h3C;
        for (int i = 0; i < NB; i++) begin
            pat[i]  = a5[i % 8];
            pat2[i] = c3[i % 8];
        end
        ones = '1;

        rst = 1'b1;
        tick(4);
        chk("reset_outputs", {frame_valid, frame_err, err_code, bit_count, match, busy}, '0);
        rst = 1'b0;
        tick(4);

        // Normal frame
        expect_reg = pat;
        send_bits(pat, NB, 1'b0);
        end_syn(pat, NB, pat);
        idle(8);
        drain(40);
        chk("normal_count_valid", n_valid, 1);
        chk("normal_match", match, 1'b1);
        chk("normal_bit_count", bit_count, 10'd490);
        chk("normal_err_code", err_code, 2'b00);
        chk("normal_low_byte", data_out[7:0], 8'hA5);
        chk("normal_data", data_out, pat);
        chk("normal_busy", busy, 1'b0);

        // Mismatch on the last bit
        expect_reg      = pat;
        expect_reg[489] = ~pat[489];
        send_bits(pat, NB, 1'b0);
        end_syn(pat, NB, expect_reg);
        idle(8);
        drain(40);
        chk("mismatch_count_valid", n_valid, 2);
        chk("mismatch_match", match, 1'b0);
        chk("mismatch_bit489", data_out[489], 1'b0);

        // Short frame
        send_bits(pat2, 100, 1'b0);
        chk("short_busy", busy, 1'b1);
        end_syn(pat2, 100, expect_reg);
        idle(8);
        drain(40);
        chk("short_err_code", err_code, 2'b01);
        chk("short_bit_count", bit_count, 10'd100);
        chk("short_data_kept", data_out[7:0], 8'hA5);

        // Long stream with no syn, then timeout
        send_bits(ones, 600, 1'b1);
        end_timeout(600);
        idle(8);
        drain(TMO + 200);
        chk("timeout_err_code", err_code, 2'b11);
        chk("timeout_bit_count", bit_count, 10'd600);
        chk("timeout_busy", busy, 1'b0);

        // Long frame terminated by syn
        send_bits(ones, 495, 1'b1);
        end_syn(ones, 495, expect_reg);
        idle(8);
        drain(40);
        chk("long_err_code", err_code, 2'b10);
        chk("long_bit_count", bit_count, 10'd495);

        // Zero-length frame
        end_syn(pat, 0, expect_reg);
        idle(8);
        drain(40);
        chk("zero_err_code", err_code, 2'b01);
        chk("zero_bit_count", bit_count, 10'd0);

        // Reset in the middle of a frame, then a full frame
        send_bits(pat2, 200, 1'b0);
        idle(4);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        chk("midreset_outputs", {data_out[7:0], err_code, bit_count, match, busy}, '0);
        expect_reg = pat2;
        send_bits(pat2, NB, 1'b0);
        end_syn(pat2, NB, pat2);
        idle(8);
        drain(40);
        chk("after_reset_data", data_out, pat2);
        chk("after_reset_low_byte", data_out[7:0], 8'h3C);
        chk("after_reset_match", match, 1'b1);

        // Back-to-back frames
        nv0        = n_valid;
        expect_reg = pat;
        send_bits(pat, NB, 1'b0);
        end_syn(pat, NB, pat);
        send_bits(pat2, NB, 1'b0);
        end_syn(pat2, NB, pat);
        idle(8);
        drain(40);
        chk("b2b_pulses", n_valid - nv0, 2);
        chk("b2b_data", data_out, pat2);
        chk("b2b_match", match, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
